// File: rtl/hci_bank_arbiter.sv
// hci_bank_arbiter: shares one TCDM bank between N_REQ ports with round-robin or
// starvation-bounded fixed priority, and sequences the test-and-set read/write pair.
module hci_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int AW        = 32,
    parameter int AWM       = 12,
    parameter int DW        = 32,
    parameter int BW        = 8,
    parameter int TS_BIT    = 21,
    parameter int MAX_STALL = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      arb_policy_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*AW-1:0]       add_i,
    input  logic [N_REQ-1:0]          wen_i,
    input  logic [N_REQ*DW-1:0]       wdata_i,
    input  logic [N_REQ*(DW/BW)-1:0]  be_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          r_valid_o,
    output logic [DW-1:0]             r_data_o,
    output logic                      mem_req_o,
    output logic [AWM-1:0]            mem_add_o,
    output logic                      mem_wen_o,
    output logic [DW-1:0]             mem_wdata_o,
    output logic [DW/BW-1:0]          mem_be_o,
    input  logic                      mem_gnt_i,
    input  logic [DW-1:0]             mem_r_data_i
);
    localparam int BEW = DW / BW;
    localparam int IW  = $clog2(N_REQ);
    localparam int SW  = $clog2(MAX_STALL + 1);

    typedef enum logic {IDLE, TS_WRITE} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, resp_idx_q, rr_win, fp_win, win;
    logic [SW-1:0]   stall_q;
    logic [AWM-1:0]  ts_add_q;
    logic [AW-1:0]   win_add;
    logic            resp_pend_q, any_req, use_rr, others, hs, ts_hit, in_ts;

    // Descending scans so the lowest-distance (or lowest-index) requester wins last.
    always_comb begin
        rr_win = '0;
        fp_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(rr_ptr_q) + k) % N_REQ]) rr_win = IW'((int'(rr_ptr_q) + k) % N_REQ);
            if (req_i[k]) fp_win = IW'(k);
        end
    end

    assign any_req = |req_i;
    assign in_ts   = state_q == TS_WRITE;
    assign use_rr  = !arb_policy_i || stall_q == SW'(MAX_STALL);
    assign win     = use_rr ? rr_win : fp_win;
    assign win_add = add_i[int'(win)*AW +: AW];
    assign others  = |(req_i & ~(N_REQ'(1) << win));
    assign hs      = rst_ni && !in_ts && any_req && mem_gnt_i;
    assign ts_hit  = hs && wen_i[win] && win_add[TS_BIT];

    assign mem_req_o   = rst_ni && (in_ts || any_req);
    assign mem_add_o   = in_ts ? ts_add_q : win_add[AWM+1:2];
    assign mem_wen_o   = in_ts ? 1'b0 : wen_i[win];
    assign mem_wdata_o = in_ts ? '1 : wdata_i[int'(win)*DW +: DW];
    assign mem_be_o    = in_ts ? '1 : be_i[int'(win)*BEW +: BEW];
    assign gnt_o       = hs ? N_REQ'(1) << win : '0;
    assign r_valid_o   = (rst_ni && resp_pend_q) ? N_REQ'(1) << resp_idx_q : '0;
    assign r_data_o    = mem_r_data_i;

    always_comb begin
        state_d = state_q;
        if (!in_ts && ts_hit) state_d = TS_WRITE;
        if (in_ts && mem_gnt_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            stall_q     <= '0;
            resp_pend_q <= 1'b0;
            resp_idx_q  <= '0;
            ts_add_q    <= '0;
        end else begin
            state_q     <= state_d;
            resp_pend_q <= hs;
            if (hs) begin
                resp_idx_q <= win;
                rr_ptr_q   <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
            end
            if (ts_hit) ts_add_q <= win_add[AWM+1:2];
            // The one-shot round-robin override is consumed only by an actual handshake.
            if (!arb_policy_i) stall_q <= '0;
            else if (!in_ts) stall_q <= use_rr ? (hs ? '0 : stall_q) : (others ? stall_q + 1'b1 : '0);
        end
    end
endmodule

// File: doc/hci_bank_arbiter.md
# hci_bank_arbiter

Per-bank arbiter and sequencer that shares one TCDM memory bank between N_REQ initiator ports. It also runs the two-phase test-and-set (TS) sequence at the bank: a locked read followed by an all-ones write. It sits between the log-interconnect routing stage and a single memory bank.

## Interface
- N_REQ, 4, number of initiator ports (≥2)
- AW, 32, initiator address width; bit TS_BIT selects TS access
- AWM, 12, bank word-address width
- DW, 32, data width
- BW, 8, byte width; BE width = DW/BW
- TS_BIT, 21, address bit flagging TS access
- MAX_STALL, 8, fixed-priority starvation limit in cycles (≥1)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- arb_policy_i  in  1  0 = round-robin, 1 = fixed priority (port 0 highest)
- req_i  in  N_REQ  request per port
- add_i  in  N_REQ×AW  byte address per port; word address = add[AWM+1:2]
- wen_i  in  N_REQ  1 = read, 0 = write
- wdata_i  in  N_REQ×DW  write data
- be_i  in  N_REQ×DW/BW  byte enables
- gnt_o  out  N_REQ  grant, one-hot or zero
- r_valid_o  out  N_REQ  response valid, one-hot or zero
- r_data_o  out  DW  response data, shared by all ports
- mem_req_o  out  1  bank request
- mem_add_o  out  AWM  bank word address
- mem_wen_o  out  1  bank read/write (1 = read)
- mem_wdata_o  out  DW  bank write data
- mem_be_o  out  DW/BW  bank byte enables
- mem_gnt_i  in  1  bank grant
- mem_r_data_i  in  DW  bank read data, valid one cycle after handshake

## Operation
- **FSM states:** IDLE and TS_WRITE.
- **IDLE arbitration:**
  - mem_req_o = |req_i.
  - A combinational winner is selected; its add/wen/wdata/be drive the mem_* outputs.
  - gnt_o[winner] = mem_gnt_i.
- **Round-robin:**
  - The winner is the first requesting port at or after rr_ptr, scanning with wrap-around.
  - On a handshake with port i, rr_ptr ← (i+1) mod N_REQ.
  - rr_ptr is unchanged when there is no handshake.
- **Fixed priority:**
  - The winner is the lowest-index requesting port.
  - stall_cnt increments each cycle in which any port other than the winner requests.
  - stall_cnt clears on any cycle with no such port.
  - When stall_cnt = MAX_STALL, the next arbitration uses the round-robin rule once, then stall_cnt clears.
  - rr_ptr is updated on every handshake in both modes.
- **Response:**
  - Every handshake, read or write, registers resp_idx and sets resp_pend.
  - The following cycle: r_valid_o[resp_idx] = 1 and r_data_o = mem_r_data_i.
  - For writes, r_data_o content is don't-care.
- **TS access:** a read handshake with add_i[winner][TS_BIT]=1 does the following.
  - The read is issued normally, with TS_BIT not forwarded.
  - The FSM moves to TS_WRITE and latches the address and ts_idx.
- **TS_WRITE:**
  - Drives mem_req_o=1, mem_wen_o=0, mem_wdata_o=all ones, mem_be_o=all ones, mem_add_o=latched address.
  - gnt_o = 0 for all ports.
  - On mem_gnt_i=1, return to IDLE. This write produces no r_valid.
  - A TS access that is a write (wen=0) is treated as a plain write.
- **Reset:**
  - rr_ptr=0, stall_cnt=0, FSM=IDLE, resp_pend=0.
  - While rst_ni=0, mem_req_o=0, gnt_o=0 and r_valid_o=0.
  - A TS_WRITE interrupted by reset is dropped (no write issued).

## Timing
- Grant is combinational: req_i→gnt_o in the same cycle, gated by mem_gnt_i.
- Handshake at cycle t → r_valid_o at t+1.
- A new handshake at t+1 is allowed (full throughput, one access per cycle).
- TS sequence:
  - Read handshake at t; r_valid_o at t+1 carries the old value.
  - Bank write at t+1, or later if mem_gnt_i=0 (the write is held until granted).
  - The earliest next grant is the cycle after the write handshake.
- No handshake (mem_gnt_i=0 or req_i=0) → r_valid_o=0 the next cycle.
- Port request inputs must stay stable until granted; the arbiter does not latch them.
- arb_policy_i changes take effect on the next arbitration; stall_cnt is cleared when arb_policy_i=0.

## Test plan
- **Round-robin fairness:** policy 0, mem_gnt_i=1, all 4 ports reading continuously → grants 0,1,2,3,0,… one per cycle; r_valid_o follows one cycle later with matching index.
- **Fixed priority plus starvation:** policy 1, MAX_STALL=8, ports 0 and 3 requesting continuously → port 0 granted for 8 cycles, then port 3 once, then port 0 again.
- **Test-and-set:** bank word 0x10 = 0x0000_0005; port 2 reads add with bit 21 set → port 2 gets 0x0000_0005 at t+1, bank write of 0xFFFF_FFFF to word 0x10 at t+1, no gnt_o at t+1; a subsequent plain read returns 0xFFFF_FFFF.
- **Bank back-pressure:** mem_gnt_i=0 for 3 cycles with port 1 requesting → gnt_o=0, r_valid_o=0, rr_ptr unchanged; grant on the first cycle mem_gnt_i=1. Repeat with mem_gnt_i=0 during TS_WRITE → write held with address stable.
- **Reset mid-TS:** assert rst_ni=0 in the TS_WRITE cycle → no bank write, all outputs 0; after release, port 0 is granted first under round-robin.
- **Write responses:** port 3 writes data 0xA5A5_A5A5 with be=4'b0011 → mem_be_o=4'b0011 and r_valid_o[3]=1 the next cycle.
